mem_port_arbiter: RTL and testbench

- Shares one external memory port between instruction fetch (IF stage) and data access (MEM stage, driven by MemRead/MemWrite from the decoder).
- Sequences each access through a request/ready handshake with the slow memory.
- Raises a global pipeline stall until every pending access of the current cycle is complete.
- Sits between the RISC-V core and the off-chip memory model.

---
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one slow memory port between fetch and data access,
// stalling the pipeline until every pending access of the current cycle is done.
module mem_port_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_ready_o,
  input  logic              dc_read_i,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_ready_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              stall_o
);
  typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I} state_t;
  state_t r_state, w_next;
  logic r_i_done, r_d_done;
  logic w_pend_d, w_pend_i;
  assign w_pend_d   = (dc_read_i | dc_write_i) & ~r_d_done;
  assign w_pend_i   = ic_req_i & ~r_i_done;
  assign stall_o    = w_pend_i | w_pend_d;
  assign ic_ready_o = r_i_done;
  assign dc_ready_o = r_d_done;
  // Data wins in IDLE: the MEM-stage access belongs to the older instruction.
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_pend_d ? SERVE_D : w_pend_i ? SERVE_I : IDLE)
                               : (mem_ready_i ? IDLE : r_state);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      ic_rdata_o  <= '0;
      dc_rdata_o  <= '0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (w_pend_d) begin
          mem_addr_o  <= dc_addr_i;
          mem_wdata_o <= dc_wdata_i;
          mem_write_o <= dc_write_i;
          mem_read_o  <= ~dc_write_i;
        end else if (w_pend_i) begin
          mem_addr_o <= ic_addr_i;
          mem_read_o <= 1'b1;
        end
      end else if (mem_ready_i) begin
        mem_read_o  <= 1'b0;
        mem_write_o <= 1'b0;
        if (r_state == SERVE_D) begin
          r_d_done <= 1'b1;
          if (mem_read_o) dc_rdata_o <= mem_rdata_i;
        end else begin
          r_i_done   <= 1'b1;
          ic_rdata_o <= mem_rdata_i;
        end
      end
      // The pipeline advances on any unstalled edge, so both requesters may be served again.
      if (!stall_o) begin
        r_i_done <= 1'b0;
        r_d_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios against a latency-programmable memory responder.
module tb_mem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ic_req_i = 1'b0;
  logic [29:0] ic_addr_i = '0;
  logic [31:0] ic_rdata_o;
  logic        ic_ready_o;
  logic        dc_read_i = 1'b0;
  logic        dc_write_i = 1'b0;
  logic [29:0] dc_addr_i = '0;
  logic [31:0] dc_wdata_i = '0;
  logic [31:0] dc_rdata_o;
  logic        dc_ready_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        stall_o;
  int tests = 0;
  int fails = 0;
  int lat = 1;
  int cnt = 0;
  logic [31:0] mem_arr [0:255];

  mem_port_arbiter #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdata_o(ic_rdata_o), .ic_ready_o(ic_ready_o),
    .dc_read_i(dc_read_i), .dc_write_i(dc_write_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_rdata_o(dc_rdata_o), .dc_ready_o(dc_ready_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory answers after the strobe has been held for lat cycles.
  always @(negedge clk_i) begin
    if (mem_read_o || mem_write_o) begin
      cnt = cnt + 1;
      if (cnt == lat) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = mem_arr[mem_addr_o[7:0]];
        if (mem_write_o) mem_arr[mem_addr_o[7:0]] = mem_wdata_o;
      end else begin
        mem_ready_i = 1'b0;
      end
    end else begin
      cnt = 0;
      mem_ready_i = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_i = 1'b0;
    dc_read_i = 1'b0;
    dc_write_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    ic_req_i = 1'b1;
    #1;
    tests++;
    if (mem_read_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== 30'h0 || mem_wdata_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h wdata=%h, want all 0", mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o);
    end
    tests++;
    if (ic_ready_o !== 1'b0 || dc_ready_o !== 1'b0 || ic_rdata_o !== 32'h0 || dc_rdata_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_rsp: icr=%b dcr=%b ic=%h dc=%h, want all 0", ic_ready_o, dc_ready_o, ic_rdata_o, dc_rdata_o);
    end
    tests++;
    if (stall_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_stall: stall=%b, want 1", stall_o);
    end
    ic_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    lat = 1;
    ic_req_i = 1'b1;
    ic_addr_i = 30'h10;
    #1;
    tests++;
    if (stall_o !== 1'b1) begin fails++; $display("FAIL fetch_c0_stall: got %b want 1", stall_o); end
    tick();
    tests++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== 30'h10 || ic_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL fetch_c1: rd=%b addr=%h icr=%b, want 1 10 0", mem_read_o, mem_addr_o, ic_ready_o);
    end
    tick();
    tests++;
    if (ic_rdata_o !== 32'h00500093 || ic_ready_o !== 1'b1 || stall_o !== 1'b0 || mem_read_o !== 1'b0) begin
      fails++;
      $display("FAIL fetch_c2: ic=%h icr=%b stall=%b rd=%b, want 00500093 1 0 0", ic_rdata_o, ic_ready_o, stall_o, mem_read_o);
    end
    ic_req_i = 1'b0;
    tick();
    tests++;
    if (mem_read_o !== 1'b0 || ic_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL fetch_c3: rd=%b icr=%b, want 0 0", mem_read_o, ic_ready_o);
    end
  endtask

  task automatic test_fetch_load();
    lat = 3;
    ic_req_i = 1'b1;
    ic_addr_i = 30'h04;
    dc_read_i = 1'b1;
    dc_addr_i = 30'h40;
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++;
      if (mem_read_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 30'h40 || stall_o !== 1'b1) begin
        fails++;
        $display("FAIL fl_data_c%0d: rd=%b wr=%b addr=%h stall=%b, want 1 0 40 1", c, mem_read_o, mem_write_o, mem_addr_o, stall_o);
      end
    end
    tick();
    tests++;
    if (dc_ready_o !== 1'b1 || dc_rdata_o !== 32'hC0DE0040 || mem_read_o !== 1'b0 || stall_o !== 1'b1) begin
      fails++;
      $display("FAIL fl_c4: dcr=%b dc=%h rd=%b stall=%b, want 1 c0de0040 0 1", dc_ready_o, dc_rdata_o, mem_read_o, stall_o);
    end
    for (int c = 5; c <= 7; c++) begin
      tick();
      tests++;
      if (mem_read_o !== 1'b1 || mem_addr_o !== 30'h04 || stall_o !== 1'b1) begin
        fails++;
        $display("FAIL fl_fetch_c%0d: rd=%b addr=%h stall=%b, want 1 04 1", c, mem_read_o, mem_addr_o, stall_o);
      end
    end
    tick();
    tests++;
    if (ic_ready_o !== 1'b1 || ic_rdata_o !== 32'hC0DE0004 || dc_ready_o !== 1'b1 || stall_o !== 1'b0) begin
      fails++;
      $display("FAIL fl_c8: icr=%b ic=%h dcr=%b stall=%b, want 1 c0de0004 1 0", ic_ready_o, ic_rdata_o, dc_ready_o, stall_o);
    end
    idle_inputs();
  endtask

  task automatic test_store();
    lat = 2;
    dc_write_i = 1'b1;
    dc_addr_i = 30'h20;
    dc_wdata_i = 32'hDEADBEEF;
    for (int c = 1; c <= 2; c++) begin
      tick();
      tests++;
      if (mem_write_o !== 1'b1 || mem_read_o !== 1'b0 || mem_addr_o !== 30'h20 || mem_wdata_o !== 32'hDEADBEEF) begin
        fails++;
        $display("FAIL store_c%0d: wr=%b rd=%b addr=%h wdata=%h, want 1 0 20 deadbeef", c, mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o);
      end
    end
    tick();
    tests++;
    if (dc_ready_o !== 1'b1 || dc_rdata_o !== 32'hC0DE0040 || mem_write_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++;
      $display("FAIL store_done: dcr=%b dc=%h wr=%b stall=%b, want 1 c0de0040 0 0", dc_ready_o, dc_rdata_o, mem_write_o, stall_o);
    end
    tests++;
    if (mem_arr[8'h20] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL store_mem: got %h want deadbeef", mem_arr[8'h20]);
    end
    idle_inputs();
  endtask

  task automatic test_latency5();
    lat = 5;
    dc_read_i = 1'b1;
    dc_write_i = 1'b1;
    dc_addr_i = 30'h33;
    dc_wdata_i = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      tick();
      tests++;
      if (mem_write_o !== 1'b1 || mem_read_o !== 1'b0 || mem_addr_o !== 30'h33 || mem_wdata_o !== 32'h12345678) begin
        fails++;
        $display("FAIL lat5_c%0d: wr=%b rd=%b addr=%h wdata=%h, want 1 0 33 12345678", c, mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o);
      end
    end
    tick();
    tests++;
    if (dc_ready_o !== 1'b1 || mem_write_o !== 1'b0 || dc_rdata_o !== 32'hC0DE0040 || mem_arr[8'h33] !== 32'h12345678) begin
      fails++;
      $display("FAIL lat5_done: dcr=%b wr=%b dc=%h mem=%h, want 1 0 c0de0040 12345678", dc_ready_o, mem_write_o, dc_rdata_o, mem_arr[8'h33]);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    lat = 4;
    ic_req_i = 1'b1;
    ic_addr_i = 30'h08;
    tick();
    tests++;
    if (mem_read_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre: rd=%b want 1", mem_read_o); end
    #1 rst_i = 1'b1;
    #1;
    tests++;
    if (mem_read_o !== 1'b0 || ic_ready_o !== 1'b0 || mem_addr_o !== 30'h0 || stall_o !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_async: rd=%b icr=%b addr=%h stall=%b, want 0 0 0 1", mem_read_o, ic_ready_o, mem_addr_o, stall_o);
    end
    #4 rst_i = 1'b0;
    tick();
    tests++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== 30'h08) begin
      fails++;
      $display("FAIL rstmid_reissue: rd=%b addr=%h, want 1 08", mem_read_o, mem_addr_o);
    end
    for (int c = 0; c < 4; c++) tick();
    tests++;
    if (ic_ready_o !== 1'b1 || ic_rdata_o !== 32'hC0DE0008 || stall_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_done: icr=%b ic=%h stall=%b, want 1 c0de0008 0", ic_ready_o, ic_rdata_o, stall_o);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    lat = 1;
    ic_req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ic_addr_i = 30'(k);
      #1;
      tests++;
      if (stall_o !== 1'b1 || mem_read_o !== 1'b0) begin
        fails++;
        $display("FAIL b2b%0d_c0: stall=%b rd=%b, want 1 0", k, stall_o, mem_read_o);
      end
      tick();
      tests++;
      if (stall_o !== 1'b1 || mem_read_o !== 1'b1 || mem_addr_o !== 30'(k)) begin
        fails++;
        $display("FAIL b2b%0d_c1: stall=%b rd=%b addr=%h, want 1 1 %0h", k, stall_o, mem_read_o, mem_addr_o, k);
      end
      tick();
      tests++;
      if (stall_o !== 1'b0 || mem_read_o !== 1'b0 || ic_ready_o !== 1'b1 || ic_rdata_o !== (32'hC0DE0000 | 32'(k))) begin
        fails++;
        $display("FAIL b2b%0d_c2: stall=%b rd=%b icr=%b ic=%h, want 0 0 1 c0de000%0d", k, stall_o, mem_read_o, ic_ready_o, ic_rdata_o, k);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hC0DE0000 | 32'(i);
    mem_arr[16] = 32'h00500093;
    test_reset();
    test_fetch();
    test_fetch_load();
    test_store();
    test_latency5();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
